// File: rtl/noc_request_axilite.sv
// noc_request_axilite: AXI-Lite slave that serialises one read or write at a time into NoC request packets
module noc_request_axilite #(
    parameter int AXI_LITE_DATA_WIDTH = 512,
    parameter int AXI_LITE_ADDR_WIDTH = 64,
    parameter int NOC_DATA_WIDTH = 64,
    parameter int MAX_OUTSTANDING = 16,
    parameter logic [13:0] DST_CHIPID = 14'd0,
    parameter logic [7:0] DST_X = 8'd0,
    parameter logic [7:0] DST_Y = 8'd0,
    parameter logic [13:0] SRC_CHIPID = 14'd0,
    parameter logic [7:0] SRC_X = 8'd0,
    parameter logic [7:0] SRC_Y = 8'd0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [AXI_LITE_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_LITE_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    output logic                               noc_valid_out,
    output logic [NOC_DATA_WIDTH-1:0]          noc_data_out,
    input  logic                               noc_ready_in,
    output logic                               transaction_type_wr,
    output logic [2:0]                         transaction_type_wr_data,
    input  logic                               txn_done
);
    localparam int BEATS = AXI_LITE_DATA_WIDTH / NOC_DATA_WIDTH;
    localparam int OFFS = $clog2(AXI_LITE_DATA_WIDTH / 8);
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [7:0] LEN_LD = 8'd2;
    localparam logic [7:0] LEN_ST = 8'(2 + BEATS);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA} state_t;

    state_t                         state;
    logic                           last_wr;
    logic                           is_store;
    logic [CW-1:0]                  credits_used;
    logic [7:0]                     mshrid;
    logic [BW-1:0]                  beat;
    logic [47:0]                    addr_q;
    logic [AXI_LITE_DATA_WIDTH-1:0] wdata_q;
    logic                           can_accept, wr_elig, rd_elig, grant_wr, grant_rd, grant;
    logic                           fire, credit_ret;
    logic [47:0]                    sel_addr;
    logic [NOC_DATA_WIDTH-1:0]      hdr0, hdr1, hdr2;
    logic                           unused_ok;

    function automatic logic [NOC_DATA_WIDTH-1:0] data_flit(
        input logic [AXI_LITE_DATA_WIDTH-1:0] d,
        input logic [BW-1:0] k
    );
        logic [NOC_DATA_WIDTH-1:0] s, r;
        s = d[k*NOC_DATA_WIDTH +: NOC_DATA_WIDTH];
        r = '0;
        for (int i = 0; i < NOC_DATA_WIDTH / 8; i++)
            r[8*i +: 8] = s[NOC_DATA_WIDTH-8-8*i +: 8];
        return r;
    endfunction

    // readies are held low during reset so nothing is accepted while the block is clearing
    assign can_accept    = !reset && state == IDLE && credits_used < CW'(MAX_OUTSTANDING);
    assign wr_elig       = can_accept && s_axi_awvalid && s_axi_wvalid;
    assign rd_elig       = can_accept && s_axi_arvalid;
    assign grant_wr      = wr_elig && (!rd_elig || !last_wr);
    assign grant_rd      = rd_elig && !grant_wr;
    assign grant         = grant_wr || grant_rd;
    assign s_axi_awready = grant_wr;
    assign s_axi_wready  = grant_wr;
    assign s_axi_arready = grant_rd;
    assign fire          = noc_valid_out && noc_ready_in;
    assign credit_ret    = txn_done && credits_used != '0;
    assign sel_addr      = grant_wr ? s_axi_awaddr[47:0] : s_axi_araddr[47:0];

    assign hdr0 = {DST_CHIPID, DST_X, DST_Y, 4'd0, grant_wr ? LEN_ST : LEN_LD,
                   grant_wr ? 8'd15 : 8'd14, mshrid, 6'd0};
    assign hdr1 = {addr_q, 3'(OFFS), 13'd0};
    assign hdr2 = {SRC_CHIPID, SRC_X, SRC_Y, 34'd0};

    assign unused_ok = ^{s_axi_wstrb, s_axi_awaddr[AXI_LITE_ADDR_WIDTH-1:48],
                         s_axi_araddr[AXI_LITE_ADDR_WIDTH-1:48], sel_addr[OFFS-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                    <= IDLE;
            last_wr                  <= 1'b0;
            is_store                 <= 1'b0;
            credits_used             <= '0;
            mshrid                   <= '0;
            beat                     <= '0;
            addr_q                   <= '0;
            wdata_q                  <= '0;
            noc_valid_out            <= 1'b0;
            noc_data_out             <= '0;
            transaction_type_wr      <= 1'b0;
            transaction_type_wr_data <= '0;
        end else begin
            transaction_type_wr <= grant;
            if (grant) begin
                transaction_type_wr_data <= {grant_wr ? 2'd2 : 2'd1, sel_addr[3]};
                last_wr                  <= grant_wr;
            end
            if (grant && !credit_ret)
                credits_used <= credits_used + 1'b1;
            else if (!grant && credit_ret)
                credits_used <= credits_used - 1'b1;
            case (state)
                IDLE: if (grant) begin
                    addr_q        <= {sel_addr[47:OFFS], {OFFS{1'b0}}};
                    wdata_q       <= s_axi_wdata;
                    is_store      <= grant_wr;
                    state         <= HDR0;
                    noc_valid_out <= 1'b1;
                    noc_data_out  <= hdr0;
                end
                HDR0: if (fire) begin
                    state        <= HDR1;
                    noc_data_out <= hdr1;
                end
                HDR1: if (fire) begin
                    state        <= HDR2;
                    noc_data_out <= hdr2;
                end
                HDR2: if (fire) begin
                    if (is_store) begin
                        state        <= DATA;
                        noc_data_out <= data_flit(wdata_q, '0);
                    end else begin
                        state         <= IDLE;
                        noc_valid_out <= 1'b0;
                        noc_data_out  <= '0;
                        mshrid        <= mshrid + 8'd1;
                    end
                end
                DATA: if (fire) begin
                    if (beat == BW'(BEATS - 1)) begin
                        state         <= IDLE;
                        noc_valid_out <= 1'b0;
                        noc_data_out  <= '0;
                        beat          <= '0;
                        mshrid        <= mshrid + 8'd1;
                    end else begin
                        beat         <= beat + 1'b1;
                        noc_data_out <= data_flit(wdata_q, beat + 1'b1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
